// File: rtl/hilo_unit_if.sv
// hilo_unit_if: bundles the decode-side op/read signals and the multiplier
// handshake of hilo_unit.
//  slave  : hilo_unit side. It receives ops, read requests and the multiplier
//           status, and drives the read data, the stall/busy/err flags and the
//           multiplier launch.
//  master : environment side, which is the decode stage plus the multiplier.
interface hilo_unit_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        err;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_stall;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    modport slave (
        input  op_valid, op, rs_data, rt_data, mf_req, mf_sel,
               mul_stall, mul_hi, mul_lo,
        output mf_data, stall, busy, err, mul_start, mul_a, mul_b
    );

    modport master (
        output op_valid, op, rs_data, rt_data, mf_req, mf_sel,
               mul_stall, mul_hi, mul_lo,
        input  mf_data, stall, busy, err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: owns the architectural HI/LO registers. It accepts
// MULT/MULTU/MTHI/MTLO, drives an external 32x32 unsigned multiplier and
// applies sign correction for MULT.
//  clk, reset : clock, asynchronous active-high reset
//  bus.op_valid/op/rs_data/rt_data : op request (0=MULT 1=MULTU 2=MTHI 3=MTLO)
//  bus.mf_req/mf_sel/mf_data       : MFHI/MFLO read (sel 1=HI), combinational
//  bus.stall/busy/err              : pipeline stall, not-idle, sticky timeout
//  bus.mul_start/mul_a/mul_b       : registered launch pulse and operands
//  bus.mul_stall/mul_hi/mul_lo     : multiplier busy flag and product
module hilo_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    hilo_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIX} state_e;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    state_e         state_q, state_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic           mul_start_q, mul_start_d;
    logic           neg_q, neg_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    prod_q, prod_d;

    // The magnitude of 0x80000000 wraps to itself, which is the correct
    // unsigned value for the multiplier.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;     // the launch strobe only ever lasts one cycle
        neg_d       = neg_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OP_MULT: begin
                            mul_a_d     = abs32(bus.rs_data);
                            mul_b_d     = abs32(bus.rt_data);
                            neg_d       = bus.rs_data[31] ^ bus.rt_data[31];
                            mul_start_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = LAUNCH;
                        end
                        OP_MULTU: begin
                            mul_a_d     = bus.rs_data;
                            mul_b_d     = bus.rt_data;
                            neg_d       = 1'b0;
                            mul_start_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = LAUNCH;
                        end
                        OP_MTHI: hi_d = bus.rs_data;
                        default: lo_d = bus.rs_data;
                    endcase
                end
            end
            LAUNCH, WAIT: begin
                // The timeout takes priority, so a stuck multiplier always
                // releases the pipeline. HI/LO are left untouched.
                if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == LAUNCH) begin
                        if (bus.mul_stall) state_d = WAIT;
                    end else if (!bus.mul_stall) begin
                        prod_d  = {bus.mul_hi, bus.mul_lo};
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    // Stall holds through FIX, so a read can never observe stale HI/LO.
    assign bus.stall     = bus.busy & (bus.op_valid | bus.mf_req);
    assign bus.mf_data   = bus.mf_sel ? hi_q : lo_q;
    assign bus.err       = err_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
    localparam int TIMEOUT = 64;
    localparam int MUL_LAT = 20;

    logic clk = 1'b0;
    logic reset;
    logic dead = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   mcnt;

    hilo_unit_if bus ();

    hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the shift-add multiplier. It raises mul_stall for MUL_LAT
    // cycles after a start pulse. When dead is set, it never responds.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mul_stall <= 1'b0;
            bus.mul_hi    <= '0;
            bus.mul_lo    <= '0;
            mcnt          <= 0;
        end else if (bus.mul_start && !dead) begin
            bus.mul_stall <= 1'b1;
            mcnt          <= MUL_LAT;
            {bus.mul_hi, bus.mul_lo} <= 64'(bus.mul_a) * 64'(bus.mul_b);
        end else if (bus.mul_stall) begin
            if (mcnt == 0) bus.mul_stall <= 1'b0;
            else           mcnt <= mcnt - 1;
        end
    end

    always @(posedge clk) if (bus.mul_start) starts <= starts + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic sel, output logic [31:0] d);
        bus.mf_sel = sel;
        #1;
        d = bus.mf_data;
    endtask

    // Presents one op for a single accepting edge. The task returns at the
    // negedge that follows acceptance.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (bus.busy && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [31:0] d;
    int          n, s0;

    initial begin
        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = 2'd0;
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        bus.mf_req   = 1'b0;
        bus.mf_sel   = 1'b0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_start", bus.mul_start, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_err", bus.err, 0);
        rd(1'b1, d); chk("rst_hi", d, 0);
        rd(1'b0, d); chk("rst_lo", d, 0);
        @(negedge clk);
        reset = 1'b0;

        // MULTU with all-ones operands. While it is in flight, MFHI must stall.
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mu_start", bus.mul_start, 1);
        chk("mu_a", bus.mul_a, 32'hFFFF_FFFF);
        chk("mu_b", bus.mul_b, 32'hFFFF_FFFF);
        bus.mf_req = 1'b1;
        rd(1'b1, d);
        chk("mu_stall", bus.stall, 1);
        @(negedge clk);
        chk("mu_pulse1", bus.mul_start, 0);
        wait_idle(200, n);
        chk("mu_done", bus.busy, 0);
        rd(1'b1, d);
        chk("mu_stall_off", bus.stall, 0);
        chk("mu_hi", d, 32'hFFFF_FFFE);
        rd(1'b0, d); chk("mu_lo", d, 32'h0000_0001);
        bus.mf_req = 1'b0;

        // MULT -3 * 5
        issue(2'd0, 32'hFFFF_FFFD, 32'd5);
        chk("m35_a", bus.mul_a, 3);
        chk("m35_b", bus.mul_b, 5);
        wait_idle(200, n);
        chk("m35_done", bus.busy, 0);
        rd(1'b1, d); chk("m35_hi", d, 32'hFFFF_FFFF);
        rd(1'b0, d); chk("m35_lo", d, 32'hFFFF_FFF1);

        // MULT with the most negative value on both sides
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        chk("mmin_a", bus.mul_a, 32'h8000_0000);
        wait_idle(200, n);
        chk("mmin_done", bus.busy, 0);
        rd(1'b1, d); chk("mmin_hi", d, 32'h4000_0000);
        rd(1'b0, d); chk("mmin_lo", d, 0);

        // MTHI with a same-cycle MFHI returns the old value, and the new value
        // is visible on the next cycle.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 2'd2; bus.rs_data = 32'h1234; bus.mf_req = 1'b1;
        rd(1'b1, d); chk("mthi_old", d, 32'h4000_0000);
        @(negedge clk);
        bus.op_valid = 1'b0;
        rd(1'b1, d);
        chk("mthi_new", d, 32'h1234);
        chk("mthi_stall", bus.stall, 0);
        bus.mf_req = 1'b0;
        issue(2'd3, 32'h55, 32'h0);
        rd(1'b1, d); chk("mtlo_hi_kept", d, 32'h1234);
        rd(1'b0, d); chk("mtlo_lo", d, 32'h55);

        // MULT 7 * -2, with MULTU 6 * 7 held on op_valid behind it
        s0 = starts;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 2'd0; bus.rs_data = 32'd7; bus.rt_data = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.op = 2'd1; bus.rs_data = 32'd6; bus.rt_data = 32'd7;
        #1;
        chk("b2b_stall", bus.stall, 1);
        wait_idle(200, n);
        chk("b2b_first_done", bus.busy, 0);
        chk("b2b_one_start", starts - s0, 1);
        rd(1'b1, d); chk("b2b_hi1", d, 32'hFFFF_FFFF);
        rd(1'b0, d); chk("b2b_lo1", d, 32'hFFFF_FFF2);
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("b2b_second_busy", bus.busy, 1);
        wait_idle(200, n);
        chk("b2b_second_done", bus.busy, 0);
        chk("b2b_two_starts", starts - s0, 2);
        rd(1'b1, d); chk("b2b_hi2", d, 0);
        rd(1'b0, d); chk("b2b_lo2", d, 42);

        // Reset while WAIT is active
        issue(2'd1, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        chk("rw_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("rw_busy", bus.busy, 0);
        chk("rw_start", bus.mul_start, 0);
        rd(1'b1, d); chk("rw_hi", d, 0);
        rd(1'b0, d); chk("rw_lo", d, 0);
        @(negedge clk);
        reset = 1'b0;
        issue(2'd1, 32'd2, 32'd3);
        wait_idle(200, n);
        chk("rw_done", bus.busy, 0);
        rd(1'b0, d); chk("rw_lo6", d, 6);

        // A multiplier that never responds must time out and leave HI/LO alone.
        dead = 1'b1;
        issue(2'd1, 32'd5, 32'd5);
        chk("to_err_early", bus.err, 0);
        wait_idle(200, n);
        chk("to_idle", bus.busy, 0);
        chk("to_cycles", (n >= TIMEOUT && n <= TIMEOUT + 2), 1);
        chk("to_err", bus.err, 1);
        rd(1'b1, d); chk("to_hi", d, 0);
        rd(1'b0, d); chk("to_lo", d, 6);
        @(negedge clk);
        chk("to_err_sticky", bus.err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
